// File: rtl/ahb_arb_if.sv
// Bus-side signal bundle for the three-master AHB arbiter.
// The arbiter connects through the slave modport; the bus side that issues
// requests and observes grants connects through the master modport.
interface ahb_arb_if;
  logic [2:0] I_AHBARB_HBUSREQ;
  logic [2:0] I_AHBARB_HLOCK;
  logic [1:0] I_AHBARB_HTRANS;
  logic       I_AHBARB_HREADY;
  logic [2:0] O_AHBARB_HGRANT;
  logic [1:0] O_AHBARB_HMASTER;
  logic       O_AHBARB_HMASTLOCK;

  modport slave (
    input  I_AHBARB_HBUSREQ,
    input  I_AHBARB_HLOCK,
    input  I_AHBARB_HTRANS,
    input  I_AHBARB_HREADY,
    output O_AHBARB_HGRANT,
    output O_AHBARB_HMASTER,
    output O_AHBARB_HMASTLOCK
  );

  modport master (
    output I_AHBARB_HBUSREQ,
    output I_AHBARB_HLOCK,
    output I_AHBARB_HTRANS,
    output I_AHBARB_HREADY,
    input  O_AHBARB_HGRANT,
    input  O_AHBARB_HMASTER,
    input  O_AHBARB_HMASTLOCK
  );
endinterface

// File: rtl/ahb_arb.sv
// Three-master AHB arbiter: round-robin grant with a per-tenure beat limit,
// locked tenures exempt from the limit, master 0 as the default master.
// HMASTER/HMASTLOCK follow the grant one accepted transfer later.
module ahb_arb #(
  parameter int unsigned P_MAX_BEATS = 16
) (
  input  logic        I_AHBARB_HCLK,
  input  logic        I_AHBARB_HRESET_N,
  ahb_arb_if.slave    bus
);

  localparam logic [4:0] BEAT_LAST = 5'(P_MAX_BEATS - 1);

  logic [1:0] owner_q,     owner_d;
  logic [2:0] grant_q,     grant_d;
  logic [4:0] beat_q,      beat_d;
  logic [1:0] hmaster_q,   hmaster_d;
  logic       hmastlock_q, hmastlock_d;

  logic [1:0] owner_idx;
  logic [2:0] owner_oh;
  logic       owner_req;
  logic       owner_lock;
  logic       others_req;
  logic       beat_acc;
  logic       limit_hit;
  logic       arb_point;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  // Arbitration decision, beat counting and data-phase tracking.
  always_comb begin
    owner_idx   = (owner_q == 2'd3) ? 2'd0 : owner_q;
    owner_oh    = 3'b001 << owner_idx;
    owner_req   = |(bus.I_AHBARB_HBUSREQ & owner_oh);
    owner_lock  = |(bus.I_AHBARB_HLOCK & owner_oh);
    others_req  = |(bus.I_AHBARB_HBUSREQ & ~owner_oh);
    beat_acc    = bus.I_AHBARB_HREADY && bus.I_AHBARB_HTRANS[1];
    limit_hit   = (beat_q == BEAT_LAST) && beat_acc && !owner_lock && others_req;
    arb_point   = bus.I_AHBARB_HREADY && (!owner_req || limit_hit);

    // Round-robin search owner+1, owner+2, owner; the owner itself is skipped
    // when the tenure limit forced this arbitration.
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(owner_idx) + k) % 3);
      if (!found && bus.I_AHBARB_HBUSREQ[cand] && !(limit_hit && cand == owner_idx)) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    owner_d = owner_idx;
    if (arb_point) begin
      owner_d = found ? pick : 2'd0;
    end
    grant_d = 3'b001 << owner_d;

    // A re-grant to the same master keeps the count running.
    beat_d = beat_q;
    if (owner_d != owner_idx) begin
      beat_d = '0;
    end else if (beat_acc && beat_q != BEAT_LAST) begin
      beat_d = beat_q + 5'd1;
    end

    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.I_AHBARB_HREADY) begin
      hmaster_d   = owner_idx;
      hmastlock_d = owner_lock;
    end
  end

  // State registers; reset forces the default master immediately.
  always_ff @(posedge I_AHBARB_HCLK or negedge I_AHBARB_HRESET_N) begin
    if (!I_AHBARB_HRESET_N) begin
      owner_q     <= '0;
      grant_q     <= 3'b001;
      beat_q      <= '0;
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.O_AHBARB_HGRANT    = grant_q;
  assign bus.O_AHBARB_HMASTER   = hmaster_q;
  assign bus.O_AHBARB_HMASTLOCK = hmastlock_q;

endmodule

// File: doc/ahb_arb.md
AHB_ARB -- requirements
Module: ahb_arb

Interface
REQ-001 SHALL have port I_AHBARB_HCLK, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port I_AHBARB_HRESET_N, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port I_AHBARB_HBUSREQ, input, 3, bus request per master (bit n = master n).
REQ-004 SHALL have port I_AHBARB_HLOCK, input, 3, locked-transfer request per master.
REQ-005 SHALL have port I_AHBARB_HTRANS, input, 2, shared bus HTRANS (IDLE=00, BUSY=01, NSEQ=10, SEQ=11).
REQ-006 SHALL have port I_AHBARB_HREADY, input, 1, shared bus HREADY from the addressed slave.
REQ-007 SHALL have port O_AHBARB_HGRANT, output, 3, one-hot grant to masters.
REQ-008 SHALL have port O_AHBARB_HMASTER, output, 2, index of the master owning the address phase.
REQ-009 SHALL have port O_AHBARB_HMASTLOCK, output, 1, current address phase is locked.
REQ-010 SHALL have parameter P_MAX_BEATS, default 16, tenure beat limit before forced re-arbitration.

Function
REQ-011 O_AHBARB_HGRANT SHALL be exactly one-hot in every cycle; master 0 is the default master.
REQ-012 SHALL hold an owner index (2 bits, valid values 0-2) equal to the granted master.
REQ-013 Arbitration point: I_AHBARB_HREADY=1 and any of: (a) owner HBUSREQ=0; (b) beat count = P_MAX_BEATS-1, a beat accepted this cycle, owner HLOCK=0, and another master requesting.
REQ-014 At an arbitration point, SHALL pick the new owner round-robin: search owner+1, owner+2, owner (mod 3) and grant the first with HBUSREQ=1.
REQ-015 Under condition (b), SHALL exclude the current owner from the search.
REQ-016 If no master requests at an arbitration point, SHALL grant master 0.
REQ-017 The grant register SHALL update on the clock edge ending the arbitration-point cycle; with HREADY=0 the grant SHALL hold.
REQ-018 HMASTER SHALL load the granted index on every edge where HREADY=1, so it trails HGRANT by one accepted transfer; it SHALL hold while HREADY=0.
REQ-019 HMASTLOCK SHALL load HLOCK[granted index] under the same condition as HMASTER.
REQ-020 Beat counter (5 bits) SHALL increment on every edge with HREADY=1 and HTRANS = NSEQ or SEQ, saturating at P_MAX_BEATS-1.
REQ-021 Beat counter SHALL clear to 0 on any edge where the grant changes.
REQ-022 BUSY and IDLE transfers SHALL not advance the beat counter.
REQ-023 While owner HLOCK=1, the tenure limit SHALL not apply; only owner HBUSREQ=0 releases the bus.
REQ-024 A re-grant to the same master SHALL not clear the beat counter.
REQ-025 Requests for the master index 3 SHALL not exist; owner index 3 is unreachable and, if ever decoded, SHALL be treated as 0.
REQ-026 Outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-027 While I_AHBARB_HRESET_N=0: HGRANT=3'b001, HMASTER=2'b00, HMASTLOCK=0, owner=0, beat counter=0, independent of clock.
REQ-028 Reset asserted mid-burst SHALL abort tenure immediately; after release, arbitration resumes from owner 0 at the first arbitration point.

Verification
REQ-029 Reset, no requests -> HGRANT=001, HMASTER=0 held indefinitely.
REQ-030 Owner 0 idle; HBUSREQ=110 with HREADY=1 -> next edge HGRANT=010; following HREADY=1 edge HMASTER=1.
REQ-031 Master 1 owns, 16 SEQ beats with HBUSREQ=111, HLOCK=000 -> after 16th accepted beat HGRANT=100, beat counter=0.
REQ-032 Same as REQ-031 with HLOCK=010 -> HGRANT stays 010 after 40 beats; drop HBUSREQ[1] -> HGRANT=100, HMASTLOCK follows HLOCK[2].
REQ-033 Arbitration point with HREADY=0 for 3 cycles -> HGRANT, HMASTER, counter unchanged until HREADY=1, then switch.
REQ-034 Assert HRESET_N=0 mid-burst owned by master 2 -> HGRANT=001, HMASTER=0, HMASTLOCK=0 without a clock edge.
